// File: rtl/dfu_boot_pkg.sv
// Shared types and constants for the DFU bootloader power-up / hand-off sequencer.
package dfu_boot_pkg;

   typedef enum logic [2:0] {
      ST_LOCK       = 3'd0,
      ST_RESET      = 3'd1,
      ST_ARMED      = 3'd2,
      ST_ACTIVE     = 3'd3,
      ST_DISCONNECT = 3'd4,
      ST_BOOT       = 3'd5
   } seq_state_e;

   // DFU states above this value mean a host is actively talking to the core.
   localparam logic [7:0] DFU_STATE_IDLE = 8'h02;

   localparam int unsigned DEF_RESET_CYCLES        = 65535;
   localparam int unsigned DEF_BOOT_TIMEOUT_CYCLES = 60000000;
   localparam int unsigned DEF_DISCONNECT_CYCLES   = 12000;
   localparam int unsigned DEF_LOCK_FILTER         = 4;

   // Down-counters run from N-1 to 0 so a state lasts exactly N cycles.
   function automatic logic [31:0] load_val(input int unsigned cycles);
      return 32'(cycles - 1);
   endfunction

endpackage

// File: rtl/dfu_boot_sequencer_lock_qualifier.sv
// Synchronises the asynchronous PLL lock and qualifies it with a run-length filter.
module lock_qualifier
   import dfu_boot_pkg::*;
#(
   parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER
) (
   input  logic clk,
   input  logic reset,
   input  logic pll_locked,
   output logic lock_q,
   output logic lock_ok
);

   localparam int unsigned   CW      = $clog2(LOCK_FILTER + 1);
   localparam logic [CW-1:0] RUN_MAX = CW'(LOCK_FILTER - 1);

   logic          meta_q, meta_d;
   logic          lock_d;
   logic [CW-1:0] run_q, run_d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      meta_d = pll_locked;
      lock_d = meta_q;
      run_d  = '0;
      if (lock_q) begin
         run_d = (run_q == RUN_MAX) ? run_q : run_q + CW'(1);
      end
   end

   // The sample that completes the run is the one that qualifies lock.
   assign lock_ok = lock_q && (run_q == RUN_MAX);

   // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         lock_q <= 1'b0;
         run_q  <= '0;
      end else begin
         meta_q <= meta_d;
         lock_q <= lock_d;
         run_q  <= run_d;
      end
   end

endmodule

// File: rtl/dfu_boot_sequencer.sv
// Bootloader sequencer: PLL lock -> DFU core reset -> USB attach -> auto-boot window
// -> USB detach -> sticky boot request. Outputs are decoded from the next state.
module dfu_boot_sequencer
   import dfu_boot_pkg::*;
#(
   parameter int unsigned RESET_CYCLES        = DEF_RESET_CYCLES,
   parameter int unsigned BOOT_TIMEOUT_CYCLES = DEF_BOOT_TIMEOUT_CYCLES,
   parameter int unsigned DISCONNECT_CYCLES   = DEF_DISCONNECT_CYCLES,
   parameter int unsigned LOCK_FILTER         = DEF_LOCK_FILTER
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic [7:0] dfu_state,
   input  logic       dfu_detach,
   input  logic       force_boot,
   output logic       core_reset,
   output logic       usb_pull_en,
   output logic       boot_now,
   output logic       autoboot_armed,
   output logic [2:0] seq_state
);

   logic lock_q;
   logic lock_ok;

   lock_qualifier #(.LOCK_FILTER(LOCK_FILTER)) u_lock_qualifier (
      .clk        (clk),
      .reset      (reset),
      .pll_locked (pll_locked),
      .lock_q     (lock_q),
      .lock_ok    (lock_ok)
   );

   seq_state_e  state_q, state_d;
   logic [31:0] rst_cnt_q, rst_cnt_d;
   logic [31:0] tmr_q, tmr_d;
   logic [31:0] dis_cnt_q, dis_cnt_d;
   logic        core_reset_q, core_reset_d;
   logic        usb_pull_en_q, usb_pull_en_d;
   logic        boot_now_q, boot_now_d;
   logic        autoboot_armed_q, autoboot_armed_d;

   logic leave_req;
   logic dfu_busy;

   assign leave_req = dfu_detach || force_boot;
   assign dfu_busy  = dfu_state > DFU_STATE_IDLE;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      tmr_d     = tmr_q;
      dis_cnt_d = dis_cnt_q;

      case (state_q)
         ST_LOCK: begin
            if (lock_ok) begin
               state_d   = ST_RESET;
               rst_cnt_d = load_val(RESET_CYCLES);
            end
         end
         ST_RESET: begin
            if (!lock_q) begin
               state_d = ST_LOCK;
            end else if (rst_cnt_q == '0) begin
               state_d = ST_ARMED;
               tmr_d   = load_val(BOOT_TIMEOUT_CYCLES);
            end else begin
               rst_cnt_d = rst_cnt_q - 32'd1;
            end
         end
         ST_ARMED: begin
            // Host activity outranks the timeout expiring on the same cycle.
            if (!lock_q) begin
               state_d = ST_LOCK;
            end else if (leave_req) begin
               state_d = ST_DISCONNECT;
            end else if (dfu_busy) begin
               state_d = ST_ACTIVE;
            end else if (tmr_q == '0) begin
               state_d = ST_DISCONNECT;
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         ST_ACTIVE: begin
            if (!lock_q) begin
               state_d = ST_LOCK;
            end else if (leave_req) begin
               state_d = ST_DISCONNECT;
            end
         end
         ST_DISCONNECT: begin
            if (dis_cnt_q == '0) begin
               state_d = ST_BOOT;
            end else begin
               dis_cnt_d = dis_cnt_q - 32'd1;
            end
         end
         ST_BOOT: begin
            state_d = ST_BOOT;
         end
         default: begin
            state_d = ST_LOCK;
         end
      endcase

      if (state_d == ST_DISCONNECT && state_q != ST_DISCONNECT) begin
         dis_cnt_d = load_val(DISCONNECT_CYCLES);
      end
   end

   always_comb begin
      core_reset_d     = 1'b1;
      usb_pull_en_d    = 1'b0;
      boot_now_d       = 1'b0;
      autoboot_armed_d = autoboot_armed_q;
      case (state_d)
         ST_LOCK, ST_RESET: autoboot_armed_d = 1'b1;
         ST_ARMED: begin
            core_reset_d     = 1'b0;
            usb_pull_en_d    = 1'b1;
            autoboot_armed_d = 1'b1;
         end
         ST_ACTIVE: begin
            core_reset_d     = 1'b0;
            usb_pull_en_d    = 1'b1;
            autoboot_armed_d = 1'b0;
         end
         // Core stays out of reset while detached so an in-flight flash write completes.
         ST_DISCONNECT: core_reset_d = 1'b0;
         ST_BOOT:       boot_now_d   = 1'b1;
         default:       autoboot_armed_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_LOCK;
         rst_cnt_q        <= '0;
         tmr_q            <= '0;
         dis_cnt_q        <= '0;
         core_reset_q     <= 1'b1;
         usb_pull_en_q    <= 1'b0;
         boot_now_q       <= 1'b0;
         autoboot_armed_q <= 1'b1;
      end else begin
         state_q          <= state_d;
         rst_cnt_q        <= rst_cnt_d;
         tmr_q            <= tmr_d;
         dis_cnt_q        <= dis_cnt_d;
         core_reset_q     <= core_reset_d;
         usb_pull_en_q    <= usb_pull_en_d;
         boot_now_q       <= boot_now_d;
         autoboot_armed_q <= autoboot_armed_d;
      end
   end

   assign core_reset     = core_reset_q;
   assign usb_pull_en    = usb_pull_en_q;
   assign boot_now       = boot_now_q;
   assign autoboot_armed = autoboot_armed_q;
   assign seq_state      = state_q;

endmodule

// File: tb/tb_dfu_boot_sequencer.sv
// Scoreboard bench: stimulus predicts each output change (value and cycle), a monitor
// pops a prediction whenever the observable output vector changes.
module tb_dfu_boot_sequencer;

   localparam int RC = 16;
   localparam int BT = 100;
   localparam int DC = 8;
   localparam int LF = 4;

   // Output vector: {seq_state[2:0], core_reset, usb_pull_en, boot_now, autoboot_armed}
   localparam logic [6:0] V_RST    = 7'b000_1001;
   localparam logic [6:0] V_RESET  = 7'b001_1001;
   localparam logic [6:0] V_ARMED  = 7'b010_0101;
   localparam logic [6:0] V_ACTIVE = 7'b011_0100;
   localparam logic [6:0] V_DISC_A = 7'b100_0001;
   localparam logic [6:0] V_DISC_N = 7'b100_0000;
   localparam logic [6:0] V_BOOT_A = 7'b101_1011;
   localparam logic [6:0] V_BOOT_N = 7'b101_1010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pll_locked = 1'b1;
   logic [7:0] dfu_state = 8'h02;
   logic       dfu_detach = 1'b0;
   logic       force_boot = 1'b0;
   logic       core_reset;
   logic       usb_pull_en;
   logic       boot_now;
   logic       autoboot_armed;
   logic [2:0] seq_state;

   dfu_boot_sequencer #(
      .RESET_CYCLES        (RC),
      .BOOT_TIMEOUT_CYCLES (BT),
      .DISCONNECT_CYCLES   (DC),
      .LOCK_FILTER         (LF)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pll_locked     (pll_locked),
      .dfu_state      (dfu_state),
      .dfu_detach     (dfu_detach),
      .force_boot     (force_boot),
      .core_reset     (core_reset),
      .usb_pull_en    (usb_pull_en),
      .boot_now       (boot_now),
      .autoboot_armed (autoboot_armed),
      .seq_state      (seq_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [6:0] vec;
      string      name;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [6:0] prev = 'x;
   logic [6:0] cur;
   exp_t       e;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      cur = {seq_state, core_reset, usb_pull_en, boot_now, autoboot_armed};
      if (cur !== prev) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cycle=%0d got=%b (no change predicted)", cyc, cur);
         end else begin
            e = sb.pop_front();
            if (cur !== e.vec || cyc != e.cyc) begin
               errors++;
               $display("FAIL %s got=%b at cycle %0d, expected=%b at cycle %0d",
                        e.name, cur, cyc, e.vec, e.cyc);
            end
         end
         prev = cur;
      end
   end

   task automatic push(input int c, input logic [6:0] vec, input string name);
      exp_t x;
      x.cyc  = c;
      x.vec  = vec;
      x.name = name;
      sb.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) tick(1);
   endtask

   // One-cycle reset; c0 is the reset edge, c0+1 the first edge out of reset.
   task automatic start_run(output int c0);
      reset = 1'b1;
      push(cyc + 1, V_RST, "reset_values");
      tick(1);
      reset = 1'b0;
      c0 = cyc;
      push(c0 + 2 + LF, V_RESET, "lock_to_reset");
   endtask

   initial begin
      int c0;

      // 1: auto-boot, with a detach pulse during RESET that must be ignored
      start_run(c0);
      push(c0 + 6 + RC, V_ARMED, "s1_armed");
      push(c0 + 6 + RC + BT, V_DISC_A, "s1_timeout_disconnect");
      push(c0 + 6 + RC + BT + DC, V_BOOT_A, "s1_boot");
      tick_to(c0 + 10);
      dfu_detach = 1'b1;
      tick(1);
      dfu_detach = 1'b0;
      tick_to(c0 + 150);

      // 2+3: activity at tmr=50 cancels auto-boot, detach later boots in DC cycles
      start_run(c0);
      push(c0 + 22, V_ARMED, "s2_armed");
      push(c0 + 72, V_ACTIVE, "s2_active");
      push(c0 + 1073, V_DISC_N, "s3_detach_disconnect");
      push(c0 + 1081, V_BOOT_N, "s3_boot");
      tick_to(c0 + 71);
      dfu_state = 8'h05;
      tick(1);
      dfu_state = 8'h02;
      tick_to(c0 + 1072);
      dfu_detach = 1'b1;
      tick(1);
      dfu_detach = 1'b0;
      tick_to(c0 + 1090);

      // 4a: activity on the tmr==0 cycle wins; force_boot held through BOOT then released
      start_run(c0);
      push(c0 + 22, V_ARMED, "s4a_armed");
      push(c0 + 122, V_ACTIVE, "s4a_collision_active");
      push(c0 + 131, V_DISC_N, "s4a_force_disconnect");
      push(c0 + 139, V_BOOT_N, "s4a_boot");
      tick_to(c0 + 121);
      dfu_state = 8'h03;
      tick(1);
      dfu_state = 8'h02;
      tick_to(c0 + 130);
      force_boot = 1'b1;
      tick_to(c0 + 150);
      force_boot = 1'b0;
      tick_to(c0 + 155);

      // 4b: detach together with activity goes to DISCONNECT
      start_run(c0);
      push(c0 + 22, V_ARMED, "s4b_armed");
      push(c0 + 41, V_DISC_A, "s4b_detach_wins");
      push(c0 + 49, V_BOOT_A, "s4b_boot");
      tick_to(c0 + 40);
      dfu_detach = 1'b1;
      dfu_state  = 8'h03;
      tick(1);
      dfu_detach = 1'b0;
      dfu_state  = 8'h02;
      tick_to(c0 + 60);

      // 5: lock glitch in RESET restarts LOCK+RESET; same glitch in DISCONNECT ignored
      start_run(c0);
      push(c0 + 11, V_RST, "s5_lock_lost");
      push(c0 + 15, V_RESET, "s5_relock_reset");
      push(c0 + 31, V_ARMED, "s5_armed");
      push(c0 + 131, V_DISC_A, "s5_disconnect");
      push(c0 + 139, V_BOOT_A, "s5_boot_despite_glitch");
      tick_to(c0 + 8);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick_to(c0 + 133);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick_to(c0 + 150);

      // 6: reset from BOOT, clean restart, force_boot pulse from ARMED
      start_run(c0);
      push(c0 + 22, V_ARMED, "s6_armed");
      push(c0 + 31, V_DISC_A, "s6_force_disconnect");
      push(c0 + 39, V_BOOT_A, "s6_boot");
      tick_to(c0 + 30);
      force_boot = 1'b1;
      tick(1);
      force_boot = 1'b0;
      tick_to(c0 + 60);

      tick(20);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d expected=0 next=%s", sb.size(), sb[0].name);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
